// File: rtl/loader_pkg.sv
// Shared types and constants for the UART note loader.
package loader_pkg;

    // Frame FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] END_BYTE  = 8'hFF;
    localparam int         NOTE_W    = 12;

    // A high-nibble carrier byte has its upper four bits clear.
    function automatic logic is_nibble_byte(input logic [7:0] b);
        return (b[7:4] == 4'h0);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver with a 2-flop input synchroniser and
// mid-bit sampling driven by a down-counter.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    logic          fall;
    rx_state_e     st_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          ferr_q;

    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;

    // Synchronise the asynchronous line; flops preset to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx};
            prev_q <= rx_s;
        end
    end

    // Bit-timing state machine: half a bit to the start centre, then whole bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (st_q)
                RX_IDLE: begin
                    if (fall) begin
                        cnt_q <= CW'(CLKS_PER_BIT / 2 - 1);
                        st_q  <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == '0) begin
                        if (rx_s) begin
                            st_q <= RX_IDLE;
                        end else begin
                            cnt_q <= CW'(CLKS_PER_BIT - 1);
                            bit_q <= '0;
                            st_q  <= RX_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= CW'(CLKS_PER_BIT - 1);
                        if (bit_q == 3'd7) begin
                            st_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == '0) begin
                        if (rx_s) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        st_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: st_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_note_loader.sv
// Serial note loader: frames UART bytes into 12-bit words and writes them
// to the note register file at consecutive addresses.
//
// state | meaning
// IDLE  | waiting for the sync byte
// HI    | expecting a high-nibble byte or the end marker
// LO    | expecting the low byte of the current word
// DONE  | end marker seen, raising done
module uart_note_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT      = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              enable,
    output logic              wen,
    output logic [ADDR_W-1:0] addr,
    output logic [NOTE_W-1:0] data,
    output logic [7:0]        last_byte,
    output logic [ADDR_W-1:0] words,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                TW       = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              frame_err;

    state_e            state_q;
    logic [3:0]        nib_q;
    logic [NOTE_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] words_q;
    logic              wen_q;
    logic              done_q;
    logic              err_q;
    logic [7:0]        last_q;
    logic [TW-1:0]     tmo_q;
    logic              in_frame;
    logic              tmo_zero;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign in_frame = (state_q == HI) || (state_q == LO);
    assign tmo_zero = (tmo_q == '0);

    // Last good byte is tracked in every state, regardless of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else if (byte_valid) begin
            last_q <= rx_byte;
        end
    end

    // Inter-byte timeout: reloaded by each byte, runs only inside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= TW'(TIMEOUT);
        end else if (byte_valid) begin
            tmo_q <= TW'(TIMEOUT);
        end else if (in_frame && !tmo_zero) begin
            tmo_q <= tmo_q - TW'(1);
        end
    end

    // Frame FSM with registered write strobe and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            nib_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            words_q <= '0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            if (wen_q) begin
                // Post-write bookkeeping; the last address saturates instead of wrapping.
                if (addr_q == ADDR_MAX) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    words_q <= words_q + ADDR_W'(1);
                    state_q <= HI;
                end
            end else if (enable) begin
                if (in_frame && (frame_err || tmo_zero)) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end else if (state_q == DONE) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end else if (byte_valid) begin
                    case (state_q)
                        IDLE: begin
                            if (rx_byte == SYNC_BYTE) begin
                                words_q <= '0;
                                addr_q  <= '0;
                                done_q  <= 1'b0;
                                err_q   <= 1'b0;
                                state_q <= HI;
                            end
                        end
                        HI: begin
                            if (rx_byte == END_BYTE) begin
                                state_q <= DONE;
                            end else if (is_nibble_byte(rx_byte)) begin
                                nib_q   <= rx_byte[3:0];
                                state_q <= LO;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                        LO: begin
                            data_q <= {nib_q, rx_byte};
                            wen_q  <= 1'b1;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
            if (!enable) begin
                state_q <= IDLE;
            end
        end
    end

    assign wen       = wen_q;
    assign addr      = addr_q;
    assign data      = data_q;
    assign last_byte = last_q;
    assign words     = words_q;
    assign busy      = in_frame;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_note_loader.sv
// Randomised + directed bench for uart_note_loader against a byte-level
// behavioural model of the framing protocol.
module tb_uart_note_loader;

    localparam int CPB = 16;
    localparam int AW  = 2;
    localparam int TMO = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          enable;
    logic          wen;
    logic [AW-1:0] addr;
    logic [11:0]   data;
    logic [7:0]    last_byte;
    logic [AW-1:0] words;
    logic          busy;
    logic          done;
    logic          err;

    uart_note_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .enable   (enable),
        .wen      (wen),
        .addr     (addr),
        .data     (data),
        .last_byte(last_byte),
        .words    (words),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: frame position, expected flags/counters and write list.
    int         m_mode = 0;   // 0 outside a frame, 1 awaiting high byte, 2 awaiting low byte
    logic [7:0] m_last = '0;
    int         m_addr = 0;
    int         m_words = 0;
    bit         m_done = 0;
    bit         m_err = 0;
    logic [3:0] m_nib = '0;
    int         exp_wr[$];
    int         obs_wr[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wen === 1'b1) obs_wr.push_back(int'({addr, data}));
    end

    task automatic model_reset();
        m_mode = 0; m_last = '0; m_addr = 0; m_words = 0;
        m_done = 0; m_err = 0; m_nib = '0;
        exp_wr.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit en);
        m_last = b;
        if (!en) return;
        case (m_mode)
            0: if (b == 8'hA5) begin
                m_mode = 1; m_addr = 0; m_words = 0; m_done = 0; m_err = 0;
            end
            1: if (b == 8'hFF) begin
                m_done = 1; m_mode = 0;
            end else if (b < 8'h10) begin
                m_nib = b[3:0]; m_mode = 2;
            end else begin
                m_err = 1; m_mode = 0;
            end
            default: begin
                exp_wr.push_back(m_addr * 4096 + int'({m_nib, b}));
                if (m_addr == (1 << AW) - 1) begin
                    m_err = 1; m_mode = 0;
                end else begin
                    m_addr++; m_words++; m_mode = 1;
                end
            end
        endcase
    endtask

    task automatic model_abort();
        if (m_mode != 0) begin
            m_err = 1; m_mode = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".err"},   32'(err),       32'(m_err));
        chk({tag, ".done"},  32'(done),      32'(m_done));
        chk({tag, ".busy"},  32'(busy),      32'(m_mode != 0));
        chk({tag, ".last"},  32'(last_byte), 32'(m_last));
        chk({tag, ".addr"},  32'(addr),      32'(m_addr));
        chk({tag, ".words"}, 32'(words),     32'(m_words));
        chk({tag, ".nwr"},   32'(obs_wr.size()), 32'(exp_wr.size()));
        while (exp_wr.size() > 0 && obs_wr.size() > 0)
            chk({tag, ".wr"}, obs_wr.pop_front(), exp_wr.pop_front());
        exp_wr.delete();
        obs_wr.delete();
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] b, input string tag);
        send_byte(b, 1'b1);
        model_byte(b, enable);
        check_all(tag);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1; rx = 1'b1; enable = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        check_all("reset");
        chk("reset.wen",  32'(wen),  32'd0);
        chk("reset.data", 32'(data), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Normal two-word load.
        xfer(8'hA5, "norm"); xfer(8'h03, "norm"); xfer(8'h21, "norm");
        xfer(8'h0B, "norm"); xfer(8'h7F, "norm"); xfer(8'hFF, "norm");

        // Protocol error, then recovery on sync.
        xfer(8'hA5, "proto"); xfer(8'h41, "proto"); xfer(8'hA5, "proto_clr");

        // A5 inside a frame is an ordinary (bad) data byte.
        xfer(8'hA5, "resync");
        xfer(8'hA5, "resync2");

        // Framing error on the second byte.
        xfer(8'hA5, "ferr");
        send_byte(8'h03, 1'b0);
        model_abort();
        check_all("ferr");

        // Timeout inside a frame.
        xfer(8'hA5, "tmo"); xfer(8'h05, "tmo");
        repeat (TMO - 40) @(negedge clk);
        check_all("tmo_pre");
        repeat (80) @(negedge clk);
        model_abort();
        check_all("tmo_post");
        xfer(8'h66, "tmo_after");

        // Address saturation with a 2-bit address.
        xfer(8'hA5, "sat");
        for (int i = 1; i <= 5; i++) begin
            xfer(8'(i), "sat");
            xfer(8'(i * 16), "sat");
        end

        // Enable dropped mid-frame.
        xfer(8'hA5, "en"); xfer(8'h03, "en");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        m_mode = 0;
        check_all("en_drop");
        xfer(8'h21, "en_low");
        enable = 1'b1;
        xfer(8'hA5, "en_re"); xfer(8'h01, "en_re"); xfer(8'h23, "en_re"); xfer(8'hFF, "en_re");

        // Reset during the 4th data bit of a byte.
        xfer(8'hA5, "rstm"); xfer(8'h03, "rstm");
        b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx = b[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_all("rst_mid");
        chk("rst_mid.data", 32'(data), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        xfer(8'hA5, "rst_re"); xfer(8'h0A, "rst_re"); xfer(8'hBC, "rst_re"); xfer(8'hFF, "rst_re");

        // Randomised frames with injected faults.
        for (int f = 0; f < 20; f++) begin
            int k;
            if ($urandom_range(0, 3) == 0) xfer(8'($urandom), "rnd_junk");
            xfer(8'hA5, "rnd_sync");
            k = $urandom_range(0, 5);
            for (int w = 0; w < k; w++) begin
                if ($urandom_range(0, 11) == 0) begin
                    xfer(8'($urandom), "rnd_bad");
                end else if ($urandom_range(0, 15) == 0) begin
                    send_byte(8'($urandom), 1'b0);
                    model_abort();
                    check_all("rnd_ferr");
                end else begin
                    xfer({4'h0, 4'($urandom)}, "rnd_hi");
                    xfer(8'($urandom), "rnd_lo");
                end
            end
            if ($urandom_range(0, 7) != 0) xfer(8'hFF, "rnd_end");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
